// File: rtl/spi_pkg.sv
// Shared definitions for the SPI ADC MISO receiver: FSM state encoding and
// default parameter values used by spi_adc_miso_rx and spi_sclk_gen.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        DONE  = 3'd3,
        GAP   = 3'd4
    } spi_state_e;

    localparam int DEF_CLK_DIV    = 2;
    localparam int DEF_CS_GAP     = 4;
    localparam int DEF_FRAME_BITS = 16;
    localparam int DEF_DATA_BITS  = 12;

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI clock generator: half-period divider plus the sclk flop. The divider is
// held at zero whenever run_i is low, so every frame starts from a clean count.
// rise_o / fall_o mark the clk edge on which a half period ends with sclk low /
// high. stop_i suppresses the falling transition so sclk parks high after the
// last bit; fall_o still fires and tells the FSM the final high phase is over.
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic run_i,
    input  logic stop_i,
    output logic sclk_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] div_q, div_d;
    logic       sclk_q, sclk_d;
    logic       half_end;

    // Half-period detection, strobes and next divider / sclk values.
    always_comb begin
        half_end = run_i && (div_q == DIV_LAST);
        rise_o   = half_end && !sclk_q;
        fall_o   = half_end && sclk_q;

        div_d = '0;
        if (run_i && !half_end) begin
            div_d = div_q + 8'd1;
        end

        sclk_d = sclk_q;
        if (!run_i) begin
            sclk_d = 1'b1;
        end else if (rise_o) begin
            sclk_d = 1'b1;
        end else if (fall_o && !stop_i) begin
            sclk_d = 1'b0;
        end
    end

    // Divider and sclk registers; sclk idles high.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            div_q  <= '0;
            sclk_q <= 1'b1;
        end else begin
            div_q  <= div_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk_o = sclk_q;

endmodule

// File: rtl/spi_adc_miso_rx.sv
// SPI ADC receiver (CPOL=1): runs one FRAME_BITS-period frame per accepted
// start, shifts miso in MSB-first on each sclk rise and presents the last
// DATA_BITS bits as sample with a one-cycle sample_valid pulse.
// Optional build macro SPI_ADC_FRAME_CHECK_EN enables the leading-bit check
// that drives frame_err; without it frame_err is tied low and the shift
// register only keeps the DATA_BITS sample bits.
// Frame-end outputs (sample, sample_valid, frame_err, cs_n release) are
// registered while in DONE and become visible in the first GAP cycle, so cs_n
// is high for CS_GAP+1 cycles between back-to-back frames.
module spi_adc_miso_rx
    import spi_pkg::*;
#(
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int CS_GAP     = DEF_CS_GAP,
    parameter int FRAME_BITS = DEF_FRAME_BITS,
    parameter int DATA_BITS  = DEF_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 miso,
    output logic                 sclk,
    output logic                 cs_n,
    output logic                 busy,
    output logic [DATA_BITS-1:0] sample,
    output logic                 sample_valid,
    output logic                 frame_err
);

    localparam int BCW = $clog2(FRAME_BITS + 1);
`ifdef SPI_ADC_FRAME_CHECK_EN
    localparam int SR_W = FRAME_BITS;
`else
    localparam int SR_W = DATA_BITS;
`endif
    localparam logic [BCW-1:0] BIT_LAST = BCW'(FRAME_BITS);
    localparam logic [7:0]     GAP_LAST = 8'(CS_GAP - 1);

    spi_state_e           state_q, state_d;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [SR_W-1:0]      shift_q, shift_d;
    logic [7:0]           gap_q, gap_d;
    logic [DATA_BITS-1:0] sample_q, sample_d;
    logic                 valid_q, valid_d;
    logic                 cs_n_q, cs_n_d;
    logic                 busy_q, busy_d;
    logic                 run, stop, rise, fall;

    assign run  = (state_q == SETUP) || (state_q == SHIFT);
    assign stop = (bit_cnt_q == BIT_LAST);

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .run_i     (run),
        .stop_i    (stop),
        .sclk_o    (sclk),
        .rise_o    (rise),
        .fall_o    (fall)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; start only matters in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SETUP;
            SETUP:   if (fall) state_d = SHIFT;
            SHIFT:   if (fall && stop) state_d = DONE;
            DONE:    state_d = GAP;
            GAP:     if (gap_q == GAP_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: counters cleared in IDLE, shift on sclk rise,
    // sample capture and output flags computed from the next state.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        gap_d     = '0;
        sample_d  = sample_q;
        valid_d   = 1'b0;

        if (state_q == IDLE) begin
            bit_cnt_d = '0;
            shift_d   = '0;
        end
        if ((state_q == SHIFT) && rise) begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
            shift_d   = {shift_q[SR_W-2:0], miso};
        end
        if (state_q == GAP) begin
            gap_d = gap_q + 8'd1;
        end
        if (state_q == DONE) begin
            sample_d = shift_q[DATA_BITS-1:0];
            valid_d  = 1'b1;
        end

        cs_n_d = !((state_d == SETUP) || (state_d == SHIFT) || (state_d == DONE));
        busy_d = (state_d != IDLE);
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
            gap_q     <= '0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            cs_n_q    <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            gap_q     <= gap_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            cs_n_q    <= cs_n_d;
            busy_q    <= busy_d;
        end
    end

`ifdef SPI_ADC_FRAME_CHECK_EN
    logic frame_err_q, frame_err_d;

    // Leading-bit check: any 1 ahead of the sample bits flags the frame.
    always_comb begin
        frame_err_d = frame_err_q;
        if (state_q == DONE) begin
            frame_err_d = |shift_q[FRAME_BITS-1:DATA_BITS];
        end
    end

    // Frame error flag register; holds until the next DONE.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
        end
    end

    assign frame_err = frame_err_q;
`else
    assign frame_err = 1'b0;
`endif

    assign cs_n         = cs_n_q;
    assign busy         = busy_q;
    assign sample       = sample_q;
    assign sample_valid = valid_q;

endmodule

// File: tb/tb_spi_adc_miso_rx.sv
// Directed testbench for spi_adc_miso_rx: a default instance (CLK_DIV=2,
// CS_GAP=4) and a fast instance (CLK_DIV=1, CS_GAP=1), each fed by a small
// ADC model that shifts a 16-bit word out MSB-first on sclk falling edges.
module tb_spi_adc_miso_rx;

`ifdef SPI_ADC_FRAME_CHECK_EN
    localparam logic EXP_FE = 1'b1;
`else
    localparam logic EXP_FE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start_a, start_b;
    logic        miso_a = 1'b0, miso_b = 1'b0;
    logic        sclk_a, sclk_b, cs_n_a, cs_n_b, busy_a, busy_b;
    logic [11:0] sample_a, sample_b;
    logic        valid_a, valid_b, fe_a, fe_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    spi_adc_miso_rx u_dut_a (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start_a),
        .miso         (miso_a),
        .sclk         (sclk_a),
        .cs_n         (cs_n_a),
        .busy         (busy_a),
        .sample       (sample_a),
        .sample_valid (valid_a),
        .frame_err    (fe_a)
    );

    spi_adc_miso_rx #(
        .CLK_DIV (1),
        .CS_GAP  (1)
    ) u_dut_b (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start_b),
        .miso         (miso_b),
        .sclk         (sclk_b),
        .cs_n         (cs_n_b),
        .busy         (busy_b),
        .sample       (sample_b),
        .sample_valid (valid_b),
        .frame_err    (fe_b)
    );

    // ADC models: next queued word loaded at cs_n fall, bits driven on sclk fall.
    logic [15:0] wq_a[$], wq_b[$];
    logic [15:0] word_a = '0, word_b = '0;
    int idx_a = 0, idx_b = 0;
    int cs_falls_a = 0, rises_a = 0, rise_base_a = 0;

    always @(negedge cs_n_a) begin
        if (wq_a.size() > 0) word_a = wq_a.pop_front();
        idx_a = 15;
        cs_falls_a++;
        rise_base_a = rises_a;
    end
    always @(negedge sclk_a) begin
        if (!cs_n_a && idx_a >= 0) begin
            miso_a = word_a[idx_a];
            idx_a--;
        end
    end
    always @(posedge sclk_a) rises_a++;

    always @(negedge cs_n_b) begin
        if (wq_b.size() > 0) word_b = wq_b.pop_front();
        idx_b = 15;
    end
    always @(negedge sclk_b) begin
        if (!cs_n_b && idx_b >= 0) begin
            miso_b = word_b[idx_b];
            idx_b--;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle_a(input string tag);
        int n = 0;
        while (busy_a && n < 300) begin tick(); n++; end
        chk(tag, busy_a, 1'b0);
    endtask

    // One frame on instance A; lat = clk edges from the start-sampling edge
    // until sample_valid is seen (300 on timeout).
    task automatic frame_a(input logic [15:0] w, output int lat);
        wq_a.push_back(w);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        lat = 0;
        while (!valid_a && lat < 300) begin tick(); lat++; end
    endtask

    initial begin
        int lat, n, hi, ng, nv, cyc, tog, first, last, busy_len, falls0;
        logic prev, prevs, counting, busy_ok, saw_valid;
        int gaps[4];
        logic [11:0] samp[3];
        int rrec[3];

        // Reset with start held high: start must be ignored.
        reset_n = 1'b0;
        start_a = 1'b1;
        start_b = 1'b1;
        repeat (3) tick();
        chk("rst_cs_n", cs_n_a, 1'b1);
        chk("rst_sclk", sclk_a, 1'b1);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_sample", sample_a, 12'h000);
        chk("rst_valid", valid_a, 1'b0);
        chk("rst_ferr", fe_a, 1'b0);
        reset_n = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        tick();
        chk("rst_start_ignored", busy_a, 1'b0);
        chk("rst_start_ignored_b", busy_b, 1'b0);

        // Basic frame.
        frame_a(16'h0A5C, lat);
        chk("basic_latency", lat, 67);
        chk("basic_sample", sample_a, 12'hA5C);
        chk("basic_ferr", fe_a, 1'b0);
        chk("basic_rises", rises_a - rise_base_a, 16);
        chk("basic_cs_released", cs_n_a, 1'b1);
        tick();
        chk("basic_valid_pulse", valid_a, 1'b0);
        wait_idle_a("basic_idle");
        chk("basic_sample_hold", sample_a, 12'hA5C);

        // Leading-bit check.
        frame_a(16'h8123, lat);
        chk("fchk_latency", lat, 67);
        chk("fchk_sample", sample_a, 12'h123);
        chk("fchk_ferr", fe_a, EXP_FE);
        wait_idle_a("fchk_idle");
        chk("fchk_ferr_hold", fe_a, EXP_FE);

        // Continuous start: three back-to-back frames.
        wq_a.push_back(16'h0001);
        wq_a.push_back(16'h0FFF);
        wq_a.push_back(16'h0800);
        start_a = 1'b1;
        nv = 0; ng = 0; hi = 0; cyc = 0;
        counting = 1'b0;
        prev = cs_n_a;
        while (nv < 3 && cyc < 600) begin
            tick();
            cyc++;
            if (cs_n_a && !prev) begin counting = 1'b1; hi = 0; end
            if (counting) begin
                if (cs_n_a) hi++;
                else begin
                    if (ng < 4) gaps[ng] = hi;
                    ng++;
                    counting = 1'b0;
                end
            end
            if (valid_a) begin
                samp[nv] = sample_a;
                rrec[nv] = rises_a - rise_base_a;
                nv++;
                if (nv == 3) start_a = 1'b0;
            end
            prev = cs_n_a;
        end
        start_a = 1'b0;
        chk("cont_frames", nv, 3);
        chk("cont_gap_count", ng, 2);
        if (nv == 3) begin
            chk("cont_sample0", samp[0], 12'h001);
            chk("cont_sample1", samp[1], 12'hFFF);
            chk("cont_sample2", samp[2], 12'h800);
            for (int i = 0; i < 3; i++) chk($sformatf("cont_rises%0d", i), rrec[i], 16);
        end
        if (ng == 2) begin
            chk("cont_gap0", gaps[0], 5);
            chk("cont_gap1", gaps[1], 5);
        end
        wait_idle_a("cont_idle");

        // Start pulse during a frame is ignored; busy stays high throughout.
        falls0 = cs_falls_a;
        wq_a.push_back(16'h0ABC);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        lat = 0;
        busy_ok = 1'b1;
        while (!valid_a && lat < 300) begin
            tick();
            lat++;
            if (!busy_a) busy_ok = 1'b0;
            start_a = (lat == 30);
        end
        start_a = 1'b0;
        chk("ign_latency", lat, 67);
        chk("ign_sample", sample_a, 12'hABC);
        busy_len = 0;
        while (busy_a && busy_len < 50) begin tick(); busy_len++; end
        chk("ign_busy_tail", busy_len, 4);
        chk("ign_busy_cont", busy_ok, 1'b1);
        repeat (20) tick();
        chk("ign_one_frame", cs_falls_a - falls0, 1);
        chk("ign_still_idle", busy_a, 1'b0);

        // Reset in the low phase of bit 7.
        wq_a.push_back(16'h0FFF);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        cyc = 0;
        while (!((rises_a - rise_base_a) == 7 && !sclk_a) && cyc < 300) begin tick(); cyc++; end
        chk("mid_reached_bit7", (cyc < 300), 1'b1);
        chk("mid_cs_low", cs_n_a, 1'b0);
        reset_n = 1'b0;
        tick();
        chk("mid_cs_n", cs_n_a, 1'b1);
        chk("mid_sclk", sclk_a, 1'b1);
        chk("mid_busy", busy_a, 1'b0);
        chk("mid_sample", sample_a, 12'h000);
        reset_n = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (valid_a) saw_valid = 1'b1;
        end
        chk("mid_no_valid", saw_valid, 1'b0);
        chk("mid_sample_after", sample_a, 12'h000);
        chk("mid_cs_idle", cs_n_a, 1'b1);

        // Fast instance: CLK_DIV=1, CS_GAP=1.
        wq_b.push_back(16'h0FFF);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        lat = 0; tog = 0; first = -1; last = -1;
        prevs = sclk_b;
        while (!valid_b && lat < 300) begin
            tick();
            lat++;
            if (sclk_b != prevs) begin
                tog++;
                if (first < 0) first = lat;
                last = lat;
            end
            prevs = sclk_b;
        end
        chk("fast_latency", lat, 34);
        chk("fast_sample", sample_b, 12'hFFF);
        chk("fast_ferr", fe_b, 1'b0);
        chk("fast_toggles", tog, 32);
        chk("fast_toggle_span", last - first, 31);
        n = 0;
        while (busy_b && n < 50) begin tick(); n++; end
        chk("fast_busy_tail", n, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
